// File: rtl/prim_reqack_src_fifo_mem.sv
// Storage array for prim_reqack_src_fifo.
// Depth x Width registers without reset, one synchronous write port and one
// asynchronous read port so the head word is visible in the same cycle its
// read pointer is.
module prim_reqack_src_fifo_mem #(
   parameter int Width = 32,
   parameter int Depth = 4,
   parameter int AddrW = 2
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];

   // Write the accepted producer word into the addressed entry.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prim_reqack_src_fifo.sv
// Source-domain front end for the req/ack synchronizer.
// Buffers producer words and presents the oldest one as a quasi-static bus
// with a level req_o; the word is popped only on the ack_i pulse, so data_o
// never moves while the far domain may be sampling it.
// Optional feature macro: PRIM_REQACK_SRC_TIMEOUT_EN adds a saturating
// req-without-ack counter and a sticky timeout_o; otherwise timeout_o is 0.
module prim_reqack_src_fifo #(
   parameter int Width         = 32,
   parameter int Depth         = 4,
   parameter int TimeoutCycles = 1024
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [Width-1:0]           in_data_i,
   output logic                       req_o,
   input  logic                       ack_i,
   output logic [Width-1:0]           data_o,
   output logic [$clog2(Depth+1)-1:0] level_o,
   output logic                       timeout_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int LvlW = $clog2(Depth + 1);

   // Reject illegal configurations at elaboration time.
   if (Width < 1 || Depth < 2 || (Depth & (Depth - 1)) != 0 || TimeoutCycles < 1) begin : g_bad_param
      $error("prim_reqack_src_fifo: illegal parameter combination");
   end

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0] level_q, level_d;
   logic            push_s;
   logic            pop_s;

   // Status outputs depend on registered occupancy only, never on in_valid_i.
   assign in_ready_o = (level_q != LvlW'(Depth));
   assign req_o      = (level_q != {LvlW{1'b0}});
   assign level_o    = level_q;

   // An ack without a pending request is ignored, so it can never underflow.
   assign push_s = in_valid_i & in_ready_o;
   assign pop_s  = req_o & ack_i;

   // Next-state for pointers and occupancy; pointers wrap at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LvlW'(1);
         2'b01:   level_d = level_q - LvlW'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards any buffered words.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= {PtrW{1'b0}};
         rd_ptr_q <= {PtrW{1'b0}};
         level_q  <= {LvlW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   prim_reqack_src_fifo_mem #(
      .Width (Width),
      .Depth (Depth),
      .AddrW (PtrW)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (push_s),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_data_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (data_o)
   );

`ifdef PRIM_REQACK_SRC_TIMEOUT_EN
   localparam int CntW = $clog2(TimeoutCycles + 1);

   logic [CntW-1:0] to_cnt_q, to_cnt_d;
   logic            timeout_q;

   // Count cycles of an outstanding request; restart on pop or when idle, saturate at the limit.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (!req_o || pop_s) begin
         to_cnt_d = {CntW{1'b0}};
      end else if (to_cnt_q == CntW'(TimeoutCycles)) begin
         to_cnt_d = to_cnt_q;
      end else begin
         to_cnt_d = to_cnt_q + CntW'(1);
      end
   end

   // Timeout counter and sticky flag; the flag only clears on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt_q  <= {CntW{1'b0}};
         timeout_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_q | (to_cnt_q == CntW'(TimeoutCycles));
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

`ifndef SYNTHESIS
   // ack_i is only legal while a request is pending; a stray one is dropped.
   a_ack_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ack_i |-> req_o)
      else $warning("ack_i seen while req_o is low; ignored");

   // Producer must hold its word while it is being back-pressured.
   a_in_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (in_valid_i && !in_ready_o) |=> (!in_valid_i || $stable(in_data_i)));

   // The bus seen by the far domain must not move until the transfer is acknowledged.
   a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_o && !ack_i) |=> $stable(data_o));
`endif

endmodule

// File: tb/tb_prim_reqack_src_fifo.sv
// Self-checking bench for prim_reqack_src_fifo: directed scenarios followed by
// a randomized producer/consumer run, all compared against a queue-based
// reference model. Define PRIM_REQACK_SRC_TIMEOUT_EN to exercise the timeout.
module tb_prim_reqack_src_fifo;

   localparam int W    = 32;
   localparam int D    = 4;
   localparam int TO   = 8;
   localparam int LVLW = $clog2(D + 1);

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            in_valid_i = 1'b0;
   logic            in_ready_o;
   logic [W-1:0]    in_data_i = '0;
   logic            req_o;
   logic            ack_i = 1'b0;
   logic [W-1:0]    data_o;
   logic [LVLW-1:0] level_o;
   logic            timeout_o;

   prim_reqack_src_fifo #(
      .Width         (W),
      .Depth         (D),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_data_i  (in_data_i),
      .req_o      (req_o),
      .ack_i      (ack_i),
      .data_o     (data_o),
      .level_o    (level_o),
      .timeout_o  (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: FIFO contents as a queue, plus timeout bookkeeping.
   logic [W-1:0] q [$];
   int           stall = 0;
   logic         to_exp = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_eq("req",     64'(req_o),      64'(q.size() != 0));
      check_eq("ready",   64'(in_ready_o), 64'(q.size() != D));
      check_eq("level",   64'(level_o),    64'(q.size()));
      check_eq("timeout", 64'(timeout_o),  64'(to_exp));
      if (q.size() > 0) begin
         check_eq("data", 64'(data_o), 64'(q[0]));
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, check at the falling edge.
   task automatic cycle(input logic v, input logic [W-1:0] d, input logic a, output logic accepted);
      int sz;
      logic push;
      logic pop;
      in_valid_i = v;
      in_data_i  = d;
      ack_i      = a;
      sz   = q.size();
      push = v && (sz < D);
      pop  = a && (sz > 0);
      @(posedge clk_i);
`ifdef PRIM_REQACK_SRC_TIMEOUT_EN
      if (stall == TO) to_exp = 1'b1;
      if (sz > 0 && !pop) stall = (stall < TO) ? stall + 1 : TO;
      else stall = 0;
`endif
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      accepted = push;
      @(negedge clk_i);
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni     = 1'b0;
      in_valid_i = 1'b0;
      ack_i      = 1'b0;
      #1;
      q.delete();
      stall  = 0;
      to_exp = 1'b0;
      check_outputs();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_outputs();
   endtask

   initial begin
      logic         acc;
      logic         have;
      logic [W-1:0] word;

      // Reset then idle.
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, acc);

      // Single word acknowledged five cycles after the push.
      cycle(1'b1, 32'hDEADBEEF, 1'b0, acc);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, acc);
      cycle(1'b0, '0, 1'b1, acc);
      cycle(1'b0, '0, 1'b0, acc);

      // Fill to Depth, offer a fifth word, then drain in order.
      for (int i = 1; i <= D; i++) cycle(1'b1, W'(i), 1'b0, acc);
      cycle(1'b1, 32'h5, 1'b0, acc);
      check_eq("full_reject", 64'(acc), 64'(0));
      for (int i = 0; i < D; i++) cycle(1'b0, '0, 1'b1, acc);

      // Simultaneous push and pop at level 2.
      cycle(1'b1, 32'hA0, 1'b0, acc);
      cycle(1'b1, 32'hA1, 1'b0, acc);
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'hB0 + W'(i), 1'b1, acc);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, acc);

      // Spurious ack while empty.
      cycle(1'b0, '0, 1'b1, acc);
      cycle(1'b0, '0, 1'b0, acc);

      // Reset in the middle of a transfer drops buffered words.
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC0 + W'(i), 1'b0, acc);
      do_reset();

`ifdef PRIM_REQACK_SRC_TIMEOUT_EN
      // Hold a request past the limit; the flag must survive the later ack.
      cycle(1'b1, 32'h77, 1'b0, acc);
      for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, acc);
      check_eq("timeout_set", 64'(timeout_o), 64'(1));
      cycle(1'b0, '0, 1'b1, acc);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, acc);
      check_eq("timeout_sticky", 64'(timeout_o), 64'(1));
      do_reset();
      // Ack in the 7th request cycle keeps the flag clear.
      cycle(1'b1, 32'h78, 1'b0, acc);
      for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, acc);
      cycle(1'b0, '0, 1'b1, acc);
      for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, acc);
      check_eq("timeout_clear", 64'(timeout_o), 64'(0));
      do_reset();
`endif

      // Randomized producer with back-pressure and random ack gaps.
      have = 1'b0;
      word = '0;
      for (int i = 0; i < 400; i++) begin
         if (!have && ($urandom_range(0, 2) != 0)) begin
            have = 1'b1;
            word = $urandom;
         end
         cycle(have, have ? word : '0, (q.size() > 0) && ($urandom_range(0, 3) == 0), acc);
         if (acc) have = 1'b0;
      end
      // Drain what is left.
      for (int i = 0; i < 2 * D; i++) cycle(1'b0, '0, q.size() > 0, acc);
      check_eq("final_level", 64'(level_o), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
